// File: rtl/step_detector.sv
// Step qualifier for accelerometer magnitude samples: hysteresis crossing, peak-width
// limit and post-step lockout, with a wrapping 16-bit step counter.
module step_detector #(
   parameter int SAMPLE_W  = 12,
   parameter int HI_THRESH = 2400,
   parameter int LO_THRESH = 2100,
   parameter int MAX_HIGH  = 50,
   parameter int MIN_GAP   = 25
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                sample_valid,
   input  logic [SAMPLE_W-1:0] sample,
   input  logic                count_clr,
   output logic                step_pulse,
   output logic                reject_pulse,
   output logic [15:0]         step_count,
   output logic [1:0]          state
);

   localparam int WIDTH_W = $clog2(MAX_HIGH + 2);
   localparam int GAP_W   = (MIN_GAP < 2) ? 1 : $clog2(MIN_GAP + 1);

   localparam logic [SAMPLE_W-1:0] HI_LEVEL  = SAMPLE_W'(HI_THRESH);
   localparam logic [SAMPLE_W-1:0] LO_LEVEL  = SAMPLE_W'(LO_THRESH);
   localparam logic [WIDTH_W-1:0]  WIDTH_LIM = WIDTH_W'(MAX_HIGH);
   localparam logic [WIDTH_W-1:0]  WIDTH_SAT = WIDTH_W'(MAX_HIGH + 1);
   localparam logic [GAP_W-1:0]    GAP_INIT  = GAP_W'(MIN_GAP);

   typedef enum logic [1:0] {
      ARMED   = 2'd0,
      HIGH    = 2'd1,
      LOCKOUT = 2'd2,
      STUCK   = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH_W-1:0] width_q, width_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic               step_d, reject_d;
   logic               is_high, is_low;

   assign is_high = (sample >= HI_LEVEL);
   assign is_low  = (sample <= LO_LEVEL);
   assign state   = state_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ARMED;
         width_q      <= '0;
         gap_q        <= '0;
         step_pulse   <= 1'b0;
         reject_pulse <= 1'b0;
         step_count   <= 16'd0;
      end else begin
         state_q      <= state_d;
         width_q      <= width_d;
         gap_q        <= gap_d;
         step_pulse   <= step_d;
         reject_pulse <= reject_d;
         // A clear wins over a coincident step; the pulse still fires.
         if (count_clr)
            step_count <= 16'd0;
         else if (step_d)
            step_count <= step_count + 16'd1;
      end
   end

   always_comb begin
      state_d  = state_q;
      width_d  = width_q;
      gap_d    = gap_q;
      step_d   = 1'b0;
      reject_d = 1'b0;
      if (sample_valid) begin
         case (state_q)
            ARMED: begin
               if (is_high) begin
                  state_d = HIGH;
                  width_d = WIDTH_W'(1);
               end
            end
            HIGH: begin
               if (is_low) begin
                  step_d  = 1'b1;
                  gap_d   = GAP_INIT;
                  state_d = (MIN_GAP == 0) ? ARMED : LOCKOUT;
               end else if (width_q >= WIDTH_LIM) begin
                  // Width saturates one past the limit; the peak is abandoned.
                  width_d  = WIDTH_SAT;
                  reject_d = 1'b1;
                  state_d  = STUCK;
               end else begin
                  width_d = width_q + WIDTH_W'(1);
               end
            end
            LOCKOUT: begin
               if (gap_q <= GAP_W'(1)) begin
                  gap_d   = '0;
                  state_d = ARMED;
               end else begin
                  gap_d = gap_q - GAP_W'(1);
               end
            end
            STUCK: begin
               if (is_low)
                  state_d = ARMED;
            end
            default: state_d = ARMED;
         endcase
      end
   end

endmodule

// File: tb/tb_step_detector.sv
// Bench for step_detector: a behavioural reference model feeds an expected-result queue
// every cycle, and scenario tasks add targeted checks on the listed behaviours.
module tb_step_detector;

   logic        clk;
   logic        rst;
   logic        sample_valid;
   logic [11:0] sample;
   logic        count_clr;
   logic        step_pulse;
   logic        reject_pulse;
   logic [15:0] step_count;
   logic [1:0]  state;

   int checks = 0;
   int errors = 0;

   // expected {step_pulse, reject_pulse, state, step_count}
   logic [19:0] exp_q[$];

   // reference model state
   int m_state = 0;
   int m_width = 0;
   int m_gap   = 0;
   int m_count = 0;

   step_detector dut (
      .clk          (clk),
      .rst          (rst),
      .sample_valid (sample_valid),
      .sample       (sample),
      .count_clr    (count_clr),
      .step_pulse   (step_pulse),
      .reject_pulse (reject_pulse),
      .step_count   (step_count),
      .state        (state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      m_state = 0;
      m_width = 0;
      m_gap   = 0;
      m_count = 0;
   endtask

   task automatic model_step(input logic v, input logic [11:0] s, input logic clr,
                             output logic [19:0] e);
      logic sp;
      logic rp;
      sp = 1'b0;
      rp = 1'b0;
      if (v) begin
         if (m_state == 0) begin
            if (s >= 12'd2400) begin
               m_state = 1;
               m_width = 1;
            end
         end else if (m_state == 1) begin
            if (s <= 12'd2100) begin
               sp      = 1'b1;
               m_gap   = 25;
               m_state = 2;
            end else begin
               m_width = m_width + 1;
               if (m_width > 50) begin
                  rp      = 1'b1;
                  m_state = 3;
               end
            end
         end else if (m_state == 2) begin
            m_gap = m_gap - 1;
            if (m_gap == 0) m_state = 0;
         end else begin
            if (s <= 12'd2100) m_state = 0;
         end
      end
      if (clr) m_count = 0;
      else if (sp) m_count = (m_count + 1) % 65536;
      e = {sp, rp, 2'(m_state), 16'(m_count)};
   endtask

   // driver + scoreboard: one clock per call
   task automatic drive(input logic v, input logic [11:0] s, input logic clr);
      logic [19:0] e;
      logic [19:0] got;
      @(negedge clk);
      sample_valid = v;
      sample       = s;
      count_clr    = clr;
      model_step(v, s, clr, e);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      got = {step_pulse, reject_pulse, state, step_count};
      e   = exp_q.pop_front();
      checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL scoreboard t=%0t: got pulse=%0b rej=%0b state=%0d count=%0d, expected pulse=%0b rej=%0b state=%0d count=%0d",
                  $time, got[19], got[18], got[17:16], got[15:0], e[19], e[18], e[17:16], e[15:0]);
      end
      sample_valid = 1'b0;
   endtask

   task automatic put(input logic [11:0] s);
      drive(1'b1, s, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 12'd1000, 1'b0);
   endtask

   task automatic drain_lockout();
      for (int i = 0; i < 25; i++) put(12'd1000);
   endtask

   task automatic test_reset();
      rst          = 1'b0;
      sample_valid = 1'b0;
      sample       = 12'd2500;
      count_clr    = 1'b0;
      model_reset();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         sample_valid = ~sample_valid;
         sample       = (i % 2 == 0) ? 12'd2500 : 12'd2000;
         @(posedge clk);
         #1;
         checks++;
         if (step_count !== 16'd0 || state !== 2'd0 || step_pulse !== 1'b0 || reject_pulse !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: count=%0d state=%0d pulse=%0b rej=%0b, expected all 0",
                     step_count, state, step_pulse, reject_pulse);
         end
      end
      @(negedge clk);
      sample_valid = 1'b0;
      rst          = 1'b1;
      for (int i = 0; i < 4; i++) put(12'd1000);
      checks++;
      if (step_count !== 16'd0 || state !== 2'd0) begin
         errors++;
         $display("FAIL reset_release: count=%0d state=%0d, expected 0 0", step_count, state);
      end
   endtask

   task automatic test_clean_step();
      put(12'd1000);
      put(12'd2500);
      put(12'd2600);
      checks++;
      if (step_pulse !== 1'b0 || state !== 2'd1) begin
         errors++;
         $display("FAIL clean_step_high: pulse=%0b state=%0d, expected 0 1", step_pulse, state);
      end
      put(12'd2000);
      checks++;
      if (step_pulse !== 1'b1 || step_count !== 16'd1 || state !== 2'd2) begin
         errors++;
         $display("FAIL clean_step: pulse=%0b count=%0d state=%0d, expected 1 1 2",
                  step_pulse, step_count, state);
      end
      idle(1);
      checks++;
      if (step_pulse !== 1'b0) begin
         errors++;
         $display("FAIL clean_step_pulse_width: pulse=%0b, expected 0", step_pulse);
      end
   endtask

   task automatic test_lockout();
      put(12'd2500);
      put(12'd2000);
      for (int i = 0; i < 22; i++) put(12'd1000);
      checks++;
      if (state !== 2'd2 || step_count !== 16'd1) begin
         errors++;
         $display("FAIL lockout_24: state=%0d count=%0d, expected 2 1", state, step_count);
      end
      put(12'd2500);
      checks++;
      if (state !== 2'd0 || step_count !== 16'd1) begin
         errors++;
         $display("FAIL lockout_end: state=%0d count=%0d, expected 0 1", state, step_count);
      end
      put(12'd2500);
      put(12'd2000);
      checks++;
      if (step_count !== 16'd2 || step_pulse !== 1'b1) begin
         errors++;
         $display("FAIL lockout_after: count=%0d pulse=%0b, expected 2 1", step_count, step_pulse);
      end
      drain_lockout();
   endtask

   task automatic test_wide_peak();
      int rejects;
      rejects = 0;
      for (int i = 0; i < 50; i++) begin
         put(12'd2500);
         if (reject_pulse === 1'b1) rejects++;
      end
      checks++;
      if (state !== 2'd1 || rejects != 0) begin
         errors++;
         $display("FAIL wide_peak_50: state=%0d rejects=%0d, expected 1 0", state, rejects);
      end
      put(12'd2500);
      checks++;
      if (reject_pulse !== 1'b1 || state !== 2'd3) begin
         errors++;
         $display("FAIL wide_peak_51: rej=%0b state=%0d, expected 1 3", reject_pulse, state);
      end
      put(12'd2500);
      checks++;
      if (reject_pulse !== 1'b0 || state !== 2'd3) begin
         errors++;
         $display("FAIL wide_peak_stuck: rej=%0b state=%0d, expected 0 3", reject_pulse, state);
      end
      put(12'd2000);
      checks++;
      if (state !== 2'd0 || step_count !== 16'd2 || step_pulse !== 1'b0) begin
         errors++;
         $display("FAIL wide_peak_exit: state=%0d count=%0d pulse=%0b, expected 0 2 0",
                  state, step_count, step_pulse);
      end
   endtask

   task automatic test_hysteresis();
      int pulses;
      pulses = 0;
      put(12'd2300);
      put(12'd2399);
      checks++;
      if (state !== 2'd0) begin
         errors++;
         $display("FAIL hyst_no_arm: state=%0d, expected 0", state);
      end
      put(12'd2400);
      checks++;
      if (state !== 2'd1) begin
         errors++;
         $display("FAIL hyst_arm_edge: state=%0d, expected 1", state);
      end
      idle(7);
      put(12'd2200);
      if (step_pulse === 1'b1) pulses++;
      idle(7);
      put(12'd2101);
      if (step_pulse === 1'b1) pulses++;
      idle(7);
      put(12'd2200);
      if (step_pulse === 1'b1) pulses++;
      idle(7);
      put(12'd2100);
      if (step_pulse === 1'b1) pulses++;
      idle(7);
      checks++;
      if (pulses != 1 || step_count !== 16'd3 || state !== 2'd2) begin
         errors++;
         $display("FAIL hyst_gaps: pulses=%0d count=%0d state=%0d, expected 1 3 2",
                  pulses, step_count, state);
      end
      // clear in lockout: counter cleared, FSM untouched
      drive(1'b0, 12'd1000, 1'b1);
      checks++;
      if (step_count !== 16'd0 || state !== 2'd2) begin
         errors++;
         $display("FAIL clr_no_fsm: count=%0d state=%0d, expected 0 2", step_count, state);
      end
      drain_lockout();
   endtask

   task automatic test_wrap_clear();
      @(negedge clk);
      sample_valid = 1'b0;
      count_clr    = 1'b0;
      force dut.step_count = 16'd65534;
      @(negedge clk);
      release dut.step_count;
      m_count = 65534;
      put(12'd2500);
      put(12'd2000);
      checks++;
      if (step_count !== 16'd65535) begin
         errors++;
         $display("FAIL wrap_max: count=%0d, expected 65535", step_count);
      end
      drain_lockout();
      put(12'd2500);
      put(12'd2000);
      checks++;
      if (step_count !== 16'd0 || step_pulse !== 1'b1) begin
         errors++;
         $display("FAIL wrap_zero: count=%0d pulse=%0b, expected 0 1", step_count, step_pulse);
      end
      drain_lockout();
      put(12'd2500);
      put(12'd2500);
      put(12'd2000);
      drain_lockout();
      put(12'd2500);
      drive(1'b1, 12'd2000, 1'b1);
      checks++;
      if (step_count !== 16'd0 || step_pulse !== 1'b1 || state !== 2'd2) begin
         errors++;
         $display("FAIL clr_with_step: count=%0d pulse=%0b state=%0d, expected 0 1 2",
                  step_count, step_pulse, state);
      end
      drain_lockout();
   endtask

   task automatic test_reset_mid_peak();
      put(12'd2500);
      put(12'd2500);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (state !== 2'd0 || step_count !== 16'd0 || step_pulse !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_peak: state=%0d count=%0d pulse=%0b, expected 0 0 0",
                  state, step_count, step_pulse);
      end
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      put(12'd2000);
      checks++;
      if (step_pulse !== 1'b0 || step_count !== 16'd0 || state !== 2'd0) begin
         errors++;
         $display("FAIL reset_abort: pulse=%0b count=%0d state=%0d, expected 0 0 0",
                  step_pulse, step_count, state);
      end
   endtask

   initial begin
      test_reset();
      test_clean_step();
      test_lockout();
      test_wide_peak();
      test_hysteresis();
      test_wrap_clear();
      test_reset_mid_peak();
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
